// File: rtl/pi1_mstr_arb_pkg.sv
// Shared definitions for the PI1 master arbiter: op codes, FSM states and a
// constant-evaluable ceil(log2) helper.
package pi1_mstr_arb_pkg;

    typedef enum logic [1:0] {
        PI1_NOP = 2'd0,
        PI1_WR  = 2'd1,
        PI1_RD  = 2'd2,
        PI1_RW  = 2'd3
    } pi1_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/pi1_mstr_arb_rrpick.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping, returned as one-hot plus index.
module pi1_mstr_arb_rrpick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    int unsigned j;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        j         = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            j = (32'(last_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o        = 1'b1;
                gnt_oh_o[j]  = 1'b1;
                gnt_idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pi1_mstr_arb.sv
// Shares one PI1 slave port between MASTERCOUNT PI1 masters: round-robin with
// bounded burst hold, one outstanding op. Optional macro PI1_MSTR_ARB_PRIO0_EN.
module pi1_mstr_arb
    import pi1_mstr_arb_pkg::*;
#(
    parameter  int unsigned ARCHBITSZ   = 32,
    parameter  int unsigned MASTERCOUNT = 2,
    parameter  int unsigned MAXHOLD     = 8,
    localparam int unsigned SELBITSZ    = ARCHBITSZ / 8,
    localparam int unsigned ADDRBITSZ   = ARCHBITSZ - clog2(SELBITSZ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_pi1_sel_i,
    output logic [ARCHBITSZ-1:0]             m_pi1_data_o,
    output logic [MASTERCOUNT-1:0]           m_pi1_rdy_o,
    output logic [1:0]                       s_pi1_op_o,
    output logic [ADDRBITSZ-1:0]             s_pi1_addr_o,
    output logic [ARCHBITSZ-1:0]             s_pi1_data_o,
    output logic [SELBITSZ-1:0]              s_pi1_sel_o,
    input  logic [ARCHBITSZ-1:0]             s_pi1_data_i,
    input  logic                             s_pi1_rdy_i,
    output logic [MASTERCOUNT-1:0]           gnt_o
);

    localparam int unsigned IDXW = clog2(MASTERCOUNT);

    arb_state_e             state_q, state_d;
    logic [MASTERCOUNT-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [7:0]             hold_q, hold_d;

    logic [MASTERCOUNT-1:0] req, pick_oh, sel_oh, rdy;
    logic [IDXW-1:0]        pick_idx, sel_idx;
    logic                   pick_any, req_g, others, stay;
    logic [1:0]             g_op;

    always_comb begin
        req = '0;
        for (int unsigned m = 0; m < MASTERCOUNT; m++)
            req[m] = (m_pi1_op_i[2*m +: 2] != PI1_NOP);
    end

    pi1_mstr_arb_rrpick #(
        .N  (MASTERCOUNT),
        .IW (IDXW)
    ) u_rrpick (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        sel_oh  = pick_oh;
        sel_idx = pick_idx;
`ifdef PI1_MSTR_ARB_PRIO0_EN
        if (req[0]) begin
            sel_oh  = MASTERCOUNT'(1);
            sel_idx = '0;
        end
`endif
    end

    assign g_op   = m_pi1_op_i[2*gnt_idx_q +: 2];
    assign req_g  = req[gnt_idx_q];
    assign others = |(req & ~gnt_q);

    // Continue the burst after a result only if the owner still wants it and
    // either it is under the hold limit or nobody else is waiting.
    always_comb begin
        stay = req_g && ((hold_q < 8'(MAXHOLD)) || !others);
`ifdef PI1_MSTR_ARB_PRIO0_EN
        if (gnt_idx_q == '0) stay = req_g;
        else                 stay = stay && !req[0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d   = GRANT;
                    gnt_d     = sel_oh;
                    gnt_idx_d = sel_idx;
                    hold_d    = '0;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_idx_q;
                    hold_d  = '0;
                end else if (s_pi1_rdy_i) begin
                    state_d = DRAIN;
                    if (hold_q < 8'(MAXHOLD)) hold_d = hold_q + 8'd1;
                end
            end
            DRAIN: begin
                if (s_pi1_rdy_i) begin
                    if (stay) begin
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        last_d  = gnt_idx_q;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IDXW'(MASTERCOUNT - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        s_pi1_op_o   = PI1_NOP;
        s_pi1_addr_o = '0;
        s_pi1_data_o = '0;
        s_pi1_sel_o  = '0;
        rdy          = '0;
        case (state_q)
            GRANT: begin
                s_pi1_op_o   = g_op;
                s_pi1_addr_o = m_pi1_addr_i[ADDRBITSZ*gnt_idx_q +: ADDRBITSZ];
                s_pi1_data_o = m_pi1_data_i[ARCHBITSZ*gnt_idx_q +: ARCHBITSZ];
                s_pi1_sel_o  = m_pi1_sel_i[SELBITSZ*gnt_idx_q +: SELBITSZ];
                rdy          = gnt_q & {MASTERCOUNT{s_pi1_rdy_i}};
            end
            DRAIN:   rdy = gnt_q & {MASTERCOUNT{s_pi1_rdy_i}};
            default: rdy = '0;
        endcase
        m_pi1_rdy_o  = rdy;
        m_pi1_data_o = (|rdy) ? s_pi1_data_i : '0;
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_pi1_mstr_arb.sv
// Self-checking bench for pi1_mstr_arb: transaction-level owner model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pi1_mstr_arb;

    localparam int MC   = 2;
    localparam int DW   = 32;
    localparam int AW   = 30;
    localparam int SW   = 4;
    localparam int MAXH = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic [2*MC-1:0]   m_op;
    logic [AW*MC-1:0]  m_addr;
    logic [DW*MC-1:0]  m_data;
    logic [SW*MC-1:0]  m_sel;
    logic [DW-1:0]     m_do;
    logic [MC-1:0]     m_rdy;
    logic [1:0]        s_op;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_dout;
    logic [SW-1:0]     s_sel;
    logic [DW-1:0]     s_din;
    logic              s_rdy;
    logic [MC-1:0]     gnt;

    pi1_mstr_arb #(.ARCHBITSZ(DW), .MASTERCOUNT(MC), .MAXHOLD(MAXH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_pi1_op_i(m_op), .m_pi1_addr_i(m_addr), .m_pi1_data_i(m_data),
        .m_pi1_sel_i(m_sel), .m_pi1_data_o(m_do), .m_pi1_rdy_o(m_rdy),
        .s_pi1_op_o(s_op), .s_pi1_addr_o(s_addr), .s_pi1_data_o(s_dout),
        .s_pi1_sel_o(s_sel), .s_pi1_data_i(s_din), .s_pi1_rdy_i(s_rdy),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    logic [1:0]  p_op   [MC][64];
    logic [AW-1:0] p_addr [MC][64];
    logic [DW-1:0] p_data [MC][64];
    logic [SW-1:0] p_sel  [MC][64];
    int unsigned p_len [MC];
    int unsigned p_ix  [MC];
    bit          m_pend[MC];
    int          first_gnt[MC];
    int          res_cyc[MC];

    bit          sl_pend;
    int          sl_cnt, sl_lat;
    bit          sl_rdy_n, sl_fix;
    logic [DW-1:0] sl_rdata;
    logic [1:0]  acc_op[$];
    int          acc_own[$];
    logic [AW-1:0] acc_addr[$];
    logic [DW-1:0] acc_data[$];

    int          md_own, md_burst, md_last;
    bit          md_busy;

    logic [MC-1:0] smp_gnt, smp_rdy;
    logic [DW-1:0] smp_do, smp_sdata;
    logic [1:0]    smp_sop;
    logic [AW-1:0] smp_saddr;
    logic [SW-1:0] smp_ssel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] cur_op(input int m);
        return (p_ix[m] < p_len[m]) ? p_op[m][p_ix[m]] : 2'd0;
    endfunction

    function automatic bit all_done();
        bit d = 1'b1;
        for (int m = 0; m < MC; m++)
            if (p_ix[m] < p_len[m] || m_pend[m]) d = 1'b0;
        return d;
    endfunction

    function automatic int next_owner(input logic [MC-1:0] r, input int last);
`ifdef PI1_MSTR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= MC; k++)
            if (r[(last + k) % MC]) return (last + k) % MC;
        return -1;
    endfunction

    task automatic add_op(input int m, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        p_op[m][p_len[m]]   = op;
        p_addr[m][p_len[m]] = a;
        p_data[m][p_len[m]] = d;
        p_sel[m][p_len[m]]  = s;
        p_len[m]++;
    endtask

    task automatic drive();
        for (int m = 0; m < MC; m++) begin
            if (p_ix[m] < p_len[m]) begin
                m_op[2*m +: 2]    = p_op[m][p_ix[m]];
                m_addr[AW*m +: AW] = p_addr[m][p_ix[m]];
                m_data[DW*m +: DW] = p_data[m][p_ix[m]];
                m_sel[SW*m +: SW]  = p_sel[m][p_ix[m]];
            end else begin
                m_op[2*m +: 2]    = 2'd0;
                m_addr[AW*m +: AW] = '0;
                m_data[DW*m +: DW] = '0;
                m_sel[SW*m +: SW]  = '0;
            end
        end
        s_rdy = sl_rdy_n;
        s_din = sl_fix ? sl_rdata : (32'hC0DE_0000 ^ 32'(cyc));
    endtask

    // One clock: sample at negedge, compare to model, advance model/slave/masters,
    // then apply next inputs just after the rising edge.
    task automatic tick();
        logic [MC-1:0] req, e_gnt, e_rdy;
        logic [1:0]    e_sop;
        logic [AW-1:0] e_saddr;
        logic [DW-1:0] e_sdata, e_do;
        logic [SW-1:0] e_ssel;
        bit keep, others;
        @(negedge clk);
        smp_gnt = gnt; smp_rdy = m_rdy; smp_do = m_do; smp_sop = s_op;
        smp_saddr = s_addr; smp_sdata = s_dout; smp_ssel = s_sel;
        for (int m = 0; m < MC; m++) req[m] = (m_op[2*m +: 2] != 2'd0);
        e_gnt = '0; e_rdy = '0; e_sop = '0; e_saddr = '0; e_sdata = '0; e_ssel = '0;
        if (md_own >= 0) begin
            e_gnt[md_own] = 1'b1;
            e_rdy[md_own] = s_rdy;
            if (!md_busy) begin
                e_sop   = m_op[2*md_own +: 2];
                e_saddr = m_addr[AW*md_own +: AW];
                e_sdata = m_data[DW*md_own +: DW];
                e_ssel  = m_sel[SW*md_own +: SW];
            end
        end
        e_do = (e_rdy != '0) ? s_din : '0;
        chk("gnt", 64'(smp_gnt), 64'(e_gnt));
        chk("m_rdy", 64'(smp_rdy), 64'(e_rdy));
        chk("m_data", 64'(smp_do), 64'(e_do));
        chk("s_op", 64'(smp_sop), 64'(e_sop));
        chk("s_addr_sel", 64'({smp_saddr, smp_ssel}), 64'({e_saddr, e_ssel}));
        chk("s_wdata", 64'(smp_sdata), 64'(e_sdata));

        if (md_own < 0) begin
            if (req != '0) begin
                md_own = next_owner(req, md_last); md_busy = 1'b0; md_burst = 0;
            end
        end else if (!md_busy) begin
            if (!req[md_own]) begin
                md_last = md_own; md_own = -1;
            end else if (s_rdy) begin
                md_busy = 1'b1;
                if (md_burst < MAXH) md_burst++;
            end
        end else if (s_rdy) begin
            md_busy = 1'b0;
            others  = (req & ~(MC'(1) << md_own)) != '0;
            keep    = req[md_own] && (md_burst < MAXH || !others);
`ifdef PI1_MSTR_ARB_PRIO0_EN
            if (md_own == 0) keep = req[0];
            else             keep = keep && !req[0];
`endif
            if (!keep) begin md_last = md_own; md_own = -1; end
        end

        if (smp_sop != 2'd0 && s_rdy) begin
            acc_op.push_back(smp_sop);
            acc_own.push_back(smp_gnt[1] ? 1 : 0);
            acc_addr.push_back(smp_saddr);
            acc_data.push_back(smp_sdata);
            sl_pend = 1'b1; sl_cnt = sl_lat;
        end else if (sl_pend && s_rdy) begin
            sl_pend = 1'b0;
        end
        if (sl_pend && sl_cnt > 0) begin sl_rdy_n = 1'b0; sl_cnt--; end
        else sl_rdy_n = 1'b1;

        for (int m = 0; m < MC; m++) begin
            if (smp_gnt[m] && first_gnt[m] < 0) first_gnt[m] = cyc;
            if (smp_rdy[m]) begin
                if (m_pend[m]) begin m_pend[m] = 1'b0; res_cyc[m] = cyc; end
                else if (cur_op(m) != 2'd0) begin m_pend[m] = 1'b1; p_ix[m]++; end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        for (int m = 0; m < MC; m++) begin
            p_len[m] = 0; p_ix[m] = 0; m_pend[m] = 1'b0; first_gnt[m] = -1; res_cyc[m] = -1;
        end
        sl_pend = 1'b0; sl_cnt = 0; sl_rdy_n = 1'b1; sl_lat = 0; sl_fix = 1'b0;
        acc_op.delete(); acc_own.delete(); acc_addr.delete(); acc_data.delete();
        md_own = -1; md_busy = 1'b0; md_burst = 0; md_last = MC - 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rdy", 64'(m_rdy), 64'(0));
        chk("rst_s_op", 64'(s_op), 64'(0));
        chk("rst_s_bus", 64'({s_addr, s_sel}), 64'(0));
        chk("rst_m_data", 64'(m_do), 64'(0));
        rst_i = 1'b1;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin tick(); n++; end
        chk("done_in_budget", 64'(all_done()), 64'(1));
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, idle, n;
        bit seen;

        // Single READ from master 0, result two cycles after acceptance.
        do_reset();
        sl_lat = 1; sl_fix = 1'b1; sl_rdata = 32'hDEADBEEF;
        add_op(0, 2'd2, 30'h100, 32'h0, 4'hF);
        drive();
        tick();
        chk("t1_gnt_req_cycle", 64'(smp_gnt), 64'(2'b00));
        tick();
        chk("t1_gnt_next", 64'(smp_gnt), 64'(2'b01));
        chk("t1_s_op", 64'(smp_sop), 64'(2));
        chk("t1_s_addr", 64'(smp_saddr), 64'(30'h100));
        tick();
        chk("t1_rdy_wait", 64'(smp_rdy), 64'(2'b00));
        tick();
        chk("t1_rdy_result", 64'(smp_rdy), 64'(2'b01));
        chk("t1_data", 64'(smp_do), 64'(32'hDEADBEEF));
        run_until_done(20);

        // Both masters streaming: ownership switches every MAXHOLD ops.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            add_op(0, 2'd2, 30'(k), 32'h0, 4'hF);
            add_op(1, 2'd1, 30'(32'h200 + k), 32'(k * 3), 4'hC);
        end
        drive();
        run_until_done(400);
        chk("t2_accepts", 64'(acc_op.size()), 64'(48));
        bad = 0;
        for (int k = 0; k < acc_own.size(); k++)
            if (acc_own[k] != (k / 8) % 2) bad++;
        chk("t2_owner_pattern_errs", 64'(bad), 64'(0));

        // Lone master 1: 20 writes back to back, no IDLE after first grant.
        do_reset();
        for (int k = 0; k < 20; k++) add_op(1, 2'd1, 30'(32'h300 + k), 32'(32'hA000 + k), 4'hF);
        drive();
        seen = 1'b0; idle = 0; n = 0;
        while (!all_done() && n < 200) begin
            tick(); n++;
            if (smp_gnt != '0) seen = 1'b1;
            else if (seen && !all_done()) idle++;
        end
        chk("t3_done", 64'(all_done()), 64'(1));
        chk("t3_accepts", 64'(acc_op.size()), 64'(20));
        chk("t3_idle_cycles", 64'(idle), 64'(0));
        bad = 0;
        foreach (acc_own[k]) if (acc_own[k] != 1) bad++;
        chk("t3_foreign_owner", 64'(bad), 64'(0));
        repeat (2) tick();

        // Asynchronous reset while an op is draining.
        do_reset();
        sl_lat = 3;
        add_op(0, 2'd2, 30'h10, 32'h0, 4'hF);
        add_op(1, 2'd2, 30'h20, 32'h0, 4'hF);
        drive();
        n = 0;
        while (!(md_own >= 0 && md_busy) && n < 20) begin tick(); n++; end
        chk("t4_reached_drain", 64'(md_busy), 64'(1));
        #2;
        s_rdy = 1'b1;
        #1;
        chk("t4_pre_gnt", 64'(gnt), 64'(2'b01));
        chk("t4_pre_rdy", 64'(m_rdy), 64'(2'b01));
        rst_i = 1'b0;
        #1;
        chk("t4_async_gnt", 64'(gnt), 64'(0));
        chk("t4_async_rdy", 64'(m_rdy), 64'(0));
        chk("t4_async_s_op", 64'(s_op), 64'(0));
        chk("t4_async_data", 64'(m_do), 64'(0));
        do_reset();
        add_op(0, 2'd2, 30'h11, 32'h0, 4'hF);
        add_op(1, 2'd2, 30'h21, 32'h0, 4'hF);
        drive();
        tick();
        tick();
        chk("t4_first_gnt_after_rst", 64'(smp_gnt), 64'(2'b01));
        run_until_done(40);

        // READWRITE from master 0 while master 1 waits.
        do_reset();
        sl_lat = 1;
        add_op(0, 2'd3, 30'h40, 32'h5, 4'hF);
        add_op(1, 2'd1, 30'h80, 32'h77, 4'h3);
        drive();
        run_until_done(40);
        chk("t5_accepts", 64'(acc_op.size()), 64'(2));
        if (acc_op.size() == 2) begin
            chk("t5_op0", 64'(acc_op[0]), 64'(3));
            chk("t5_own0", 64'(acc_own[0]), 64'(0));
            chk("t5_addr0", 64'(acc_addr[0]), 64'(30'h40));
            chk("t5_data0", 64'(acc_data[0]), 64'(32'h5));
            chk("t5_op1", 64'(acc_op[1]), 64'(1));
            chk("t5_own1", 64'(acc_own[1]), 64'(1));
        end
        chk("t5_m1_gnt_after_m0_result", 64'(first_gnt[1]), 64'(res_cyc[0] + 2));

`ifdef PI1_MSTR_ARB_PRIO0_EN
        // Master 0 preempts master 1 at the end of its current op.
        do_reset();
        sl_lat = 1;
        for (int k = 0; k < 3; k++) add_op(1, 2'd1, 30'(32'h500 + k), 32'(k), 4'hF);
        drive();
        n = 0;
        while (!(md_own == 1 && md_busy) && n < 20) begin tick(); n++; end
        add_op(0, 2'd2, 30'h600, 32'h0, 4'hF);
        drive();
        run_until_done(60);
        chk("t6_accepts", 64'(acc_own.size()), 64'(4));
        if (acc_own.size() == 4) begin
            chk("t6_own0", 64'(acc_own[0]), 64'(1));
            chk("t6_own1", 64'(acc_own[1]), 64'(0));
            chk("t6_own2", 64'(acc_own[2]), 64'(1));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
